// File: rtl/stim_player.sv
// Stimulus sequencer: streams a loadable item table to a BFM over valid/ready,
// in one-shot or looping passes, with sticky stop and a one-cycle done pulse.
module stim_player #(
    parameter int ITEM_WIDTH = 16,
    parameter int LANES      = 2,
    parameter int DEPTH      = 100,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [ITEM_WIDTH-1:0] wr_data_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  loop_i,
    input  logic [AW:0]           len_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ITEM_WIDTH-1:0] lane_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           count_o,
    output logic [0:0]            state_o
);
    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_RUN  = 1'b1;
    localparam int          LANE_W  = ITEM_WIDTH / LANES;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [ITEM_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state_q;
    logic [AW-1:0]         ptr_q;
    logic [AW-1:0]         last_q;
    logic                  loop_q;
    logic                  stop_pend_q;
    logic [ITEM_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  done_q;
    logic [31:0]           count_q;

    logic [AW:0]           len_eff;
    logic [AW-1:0]         ptr_nxt;
    logic                  accept;
    logic                  at_last;

    // Handshake: an item transfers on any cycle where out_valid_o and
    // out_ready_i are both high; once raised, valid and data stay put until then.
    always_comb begin
        len_eff = len_i;
        if (len_i == '0 || len_i > DEPTH_L) begin
            len_eff = DEPTH_L;
        end
        ptr_nxt = ptr_q + AW'(1);
        accept  = valid_q & out_ready_i;
        at_last = (ptr_q == last_q);
    end

    // Table writes are never forwarded to the output register.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && wr_addr_i < AW'(DEPTH)) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            last_q      <= '0;
            loop_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        last_q      <= AW'(len_eff - (AW+1)'(1));
                        loop_q      <= loop_i;
                        ptr_q       <= '0;
                        data_q      <= mem[0];
                        valid_q     <= 1'b1;
                        count_q     <= '0;
                        stop_pend_q <= 1'b0;
                        state_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        count_q <= count_q + 32'd1;
                        if (stop_i || stop_pend_q || (at_last && !loop_q)) begin
                            valid_q     <= 1'b0;
                            done_q      <= 1'b1;
                            stop_pend_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else if (at_last) begin
                            ptr_q  <= '0;
                            data_q <= mem[0];
                        end else begin
                            ptr_q  <= ptr_nxt;
                            data_q <= mem[ptr_nxt];
                        end
                    end else if (stop_i) begin
                        stop_pend_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_data_o[k*LANE_W +: LANE_W] = data_q[k*LANE_W +: LANE_W];
    end

    assign out_valid_o = valid_q;
    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = done_q;
    assign count_o     = count_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_stim_player.sv
// Directed bench for stim_player: reset, one-shot, backpressure, loop with stop,
// mid-run reset, and full-depth playback with length clamping.
module tb_stim_player;
    localparam int ITEM_WIDTH = 16;
    localparam int DEPTH      = 100;
    localparam int AW         = $clog2(DEPTH);

    logic                  clk = 1'b0;
    logic                  reset_i = 1'b0;
    logic                  wr_en_i = 1'b0;
    logic [AW-1:0]         wr_addr_i = '0;
    logic [ITEM_WIDTH-1:0] wr_data_i = '0;
    logic                  start_i = 1'b0;
    logic                  stop_i = 1'b0;
    logic                  loop_i = 1'b0;
    logic [AW:0]           len_i = '0;
    logic                  out_valid_o;
    logic                  out_ready_i = 1'b0;
    logic [ITEM_WIDTH-1:0] lane_data_o;
    logic                  busy_o;
    logic                  done_o;
    logic [31:0]           count_o;
    logic [0:0]            state_o;

    int n_pass  = 0;
    int n_total = 0;

    logic [ITEM_WIDTH-1:0] tbl [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    logic [ITEM_WIDTH-1:0] exp_q [$];

    stim_player #(.ITEM_WIDTH(ITEM_WIDTH), .LANES(2), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_i(reset_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i),
        .len_i(len_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .lane_data_o(lane_data_o), .busy_o(busy_o), .done_o(done_o),
        .count_o(count_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic write_item(input int addr, input logic [ITEM_WIDTH-1:0] data);
        wr_en_i   = 1'b1;
        wr_addr_i = AW'(addr);
        wr_data_i = data;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic start_run(input int len, input logic lp);
        len_i   = (AW+1)'(len);
        loop_i  = lp;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        // 1: start pulsed under reset is not taken
        reset_i = 1'b0;
        start_i = 1'b1;
        out_ready_i = 1'b1;
        repeat (10) tick();
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_count", count_o, 32'd0);
        check("rst_data", 32'(lane_data_o), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        start_i = 1'b0;
        reset_i = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid_o), 32'd0);

        // 2: one-shot pass of four items at full throughput
        for (int i = 0; i < 4; i++) write_item(i, tbl[i]);
        out_ready_i = 1'b1;
        start_run(4, 1'b0);
        check("os_busy", 32'(busy_o), 32'd1);
        check("os_count0", count_o, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("os_valid", 32'(out_valid_o), 32'd1);
            check("os_lane0", 32'(lane_data_o[7:0]), 32'(2*i + 1));
            check("os_lane1", 32'(lane_data_o[15:8]), 32'(2*i + 2));
            check("os_done_low", 32'(done_o), 32'd0);
            tick();
        end
        check("os_done", 32'(done_o), 32'd1);
        check("os_valid_end", 32'(out_valid_o), 32'd0);
        check("os_busy_end", 32'(busy_o), 32'd0);
        check("os_count", count_o, 32'd4);
        tick();
        check("os_done_pulse", 32'(done_o), 32'd0);
        check("os_count_hold", count_o, 32'd4);

        // 3: backpressure holds item 1
        start_run(4, 1'b0);
        tick();
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data", 32'(lane_data_o), 32'h0403);
            check("bp_hold_valid", 32'(out_valid_o), 32'd1);
            check("bp_hold_count", count_o, 32'd1);
        end
        out_ready_i = 1'b1;
        tick();
        check("bp_resume2", 32'(lane_data_o), 32'h0605);
        tick();
        check("bp_resume3", 32'(lane_data_o), 32'h0807);
        tick();
        check("bp_done", 32'(done_o), 32'd1);
        check("bp_count", count_o, 32'd4);

        // 4: loop of three items, stop on the 7th accept
        tick();
        start_run(3, 1'b1);
        check("lp_item0", 32'(lane_data_o), 32'(tbl[0]));
        for (int i = 1; i < 7; i++) begin
            tick();
            check("lp_item", 32'(lane_data_o), 32'(tbl[i % 3]));
            check("lp_valid", 32'(out_valid_o), 32'd1);
            check("lp_count", count_o, 32'(i));
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("lp_done", 32'(done_o), 32'd1);
        check("lp_valid_end", 32'(out_valid_o), 32'd0);
        check("lp_state", 32'(state_o), 32'd0);
        check("lp_count_end", count_o, 32'd7);

        // sticky stop: stop seen without accept, exit on the next accept
        tick();
        start_run(4, 1'b1);
        out_ready_i = 1'b0;
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("st_pending", 32'(out_valid_o), 32'd1);
        out_ready_i = 1'b1;
        tick();
        check("st_done", 32'(done_o), 32'd1);
        check("st_count", count_o, 32'd1);

        // 5: reset mid-run, then replay from item 0
        tick();
        start_run(4, 1'b0);
        tick();
        tick();
        check("mr_item2", 32'(lane_data_o), 32'h0605);
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        check("mr_valid", 32'(out_valid_o), 32'd0);
        check("mr_busy", 32'(busy_o), 32'd0);
        check("mr_done", 32'(done_o), 32'd0);
        check("mr_count", count_o, 32'd0);
        start_run(4, 1'b0);
        check("mr_replay0", 32'(lane_data_o), 32'h0201);
        tick();
        check("mr_replay1", 32'(lane_data_o), 32'h0403);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("mr_stop_done", 32'(done_o), 32'd1);

        // 6: full-depth table, out-of-range write ignored, len 0 plays DEPTH items
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b;
            b = 8'(i);
            write_item(i, {b ^ 8'h5a, b});
            exp_q.push_back({b ^ 8'h5a, b});
        end
        write_item(DEPTH + 1, 16'hdead);
        start_run(0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            check("fd_item", 32'(lane_data_o), 32'(exp_q[i]));
            check("fd_count", count_o, 32'(i));
            tick();
        end
        check("fd_done", 32'(done_o), 32'd1);
        check("fd_count_end", count_o, 32'(DEPTH));

        // len above DEPTH clamps to DEPTH; loop wraps to item 0 with no bubble
        tick();
        start_run(200, 1'b1);
        repeat (DEPTH) tick();
        check("cl_wrap_item", 32'(lane_data_o), 32'(exp_q[0]));
        check("cl_wrap_valid", 32'(out_valid_o), 32'd1);
        check("cl_wrap_count", count_o, 32'(DEPTH));
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("cl_done", 32'(done_o), 32'd1);
        check("cl_count", count_o, 32'(DEPTH + 1));
        while (exp_q.size() > 0) void'(exp_q.pop_front());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
